mem_dp: RTL and testbench

Dual-port 24-bit-word data memory that answers the MA/MO memory protocol. Each port latches an address presented by MA in one cycle, then serves MO's 24-bit or 48-bit load/store on that port in the following cycle, packing and unpacking two adjacent 24-bit words little-endian when the port's 48-bit flag is set. After reset, a clear sequencer zeroes the array before the block reports ready.

---
 rtl/mem_dp.sv | 123 ++++++++++++
 tb/tb_mem_dp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dp.sv
// mem_dp: dual-port 24-bit word memory answering the MA/MO protocol.
// MA latches an address, MO does a 24/48-bit load/store next cycle; the array is zeroed after reset.
module mem_dp #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        iw_clk,
  input  logic        iw_rst_n,
  input  logic [47:0] iw_mem_addr   [0:1],
  input  logic        iw_mem_addr_v [0:1],
  input  logic        iw_mem_we     [0:1],
  input  logic [47:0] iw_mem_wdata  [0:1],
  input  logic        iw_mem_is48   [0:1],
  output logic [47:0] ow_mem_rdata  [0:1],
  output logic        ow_mem_err    [0:1],
  output logic        ow_ready
);

  localparam int DEPTH = 32'd1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] IDX_MAX = {DEPTH_LOG2{1'b1}};
  localparam logic [47-DEPTH_LOG2:0] HI_ZERO = {(48-DEPTH_LOG2){1'b0}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_r;
  logic [DEPTH_LOG2-1:0] cnt_r;
  logic                  ready_r;
  logic [47:0]           addr_r   [0:1];
  logic                  av_r     [0:1];
  logic [23:0]           mem_r    [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] idx_s    [0:1];
  logic [DEPTH_LOG2-1:0] idx_hi_s [0:1];
  logic                  oor_s    [0:1];
  logic                  wr_en_s  [0:1];

  assign ow_ready = ready_r;

  // Clear sequencer: walks every index once after reset, then holds READY.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {DEPTH_LOG2{1'b0}};
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + IDX_ONE;
          if (cnt_r == IDX_MAX) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end else begin
            ready_r <= 1'b0;
          end
        end
        ST_READY: ready_r <= 1'b1;
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {DEPTH_LOG2{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Per-port address latch; valid lasts exactly one cycle per MA request.
  always_ff @(posedge iw_clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!iw_rst_n) begin
        addr_r[p] <= 48'd0;
        av_r[p]   <= 1'b0;
      end else if (iw_mem_addr_v[p]) begin
        addr_r[p] <= iw_mem_addr[p];
        av_r[p]   <= 1'b1;
      end else begin
        av_r[p]   <= 1'b0;
      end
    end
  end

  // Range check, read mux and write qualification; the 48-bit high word must not wrap.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx_s[p]    = addr_r[p][DEPTH_LOG2-1:0];
      idx_hi_s[p] = idx_s[p] + IDX_ONE;
      oor_s[p]    = (addr_r[p][47:DEPTH_LOG2] != HI_ZERO) |
                    (iw_mem_is48[p] & (idx_s[p] == IDX_MAX));
      wr_en_s[p]  = ready_r & av_r[p] & iw_mem_we[p] & ~oor_s[p];
      ow_mem_err[p] = ready_r & av_r[p] & (iw_mem_we[p] | av_r[p]) & oor_s[p];
      if (ready_r & av_r[p] & ~oor_s[p]) begin
        if (iw_mem_is48[p]) begin
          ow_mem_rdata[p] = {mem_r[idx_hi_s[p]], mem_r[idx_s[p]]};
        end else begin
          ow_mem_rdata[p] = {24'd0, mem_r[idx_s[p]]};
        end
      end else begin
        ow_mem_rdata[p] = 48'd0;
      end
    end
  end

  // Array update: port 1 is applied last so it wins any same-word collision.
  always_ff @(posedge iw_clk) begin
    if (iw_rst_n) begin
      if (state_r == ST_CLEAR) begin
        mem_r[cnt_r] <= 24'd0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (wr_en_s[p]) begin
            mem_r[idx_s[p]] <= iw_mem_wdata[p][23:0];
            if (iw_mem_is48[p]) begin
              mem_r[idx_hi_s[p]] <= iw_mem_wdata[p][47:24];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_dp.sv
// Self-checking bench for mem_dp (DEPTH_LOG2=4) using a word model and an expected-result queue.
module tb_mem_dp;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] addr   [0:1];
  logic        addr_v [0:1];
  logic        we     [0:1];
  logic [47:0] wdata  [0:1];
  logic        is48   [0:1];
  logic [47:0] rdata  [0:1];
  logic        err    [0:1];
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] model [0:DEPTH-1];
  logic        model_ready = 1'b0;

  typedef struct {
    logic [47:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        en;
    logic [47:0] addr;
    logic        we;
    logic [47:0] wdata;
    logic        is48;
  } op_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_dp #(.DEPTH_LOG2(DL)) dut (
    .iw_clk        (clk),
    .iw_rst_n      (rst_n),
    .iw_mem_addr   (addr),
    .iw_mem_addr_v (addr_v),
    .iw_mem_we     (we),
    .iw_mem_wdata  (wdata),
    .iw_mem_is48   (is48),
    .ow_mem_rdata  (rdata),
    .ow_mem_err    (err),
    .ow_ready      (ready)
  );

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic en, input logic [47:0] a, input logic w,
                             input logic [47:0] d, input logic w48);
    op_t o;
    o.en = en; o.addr = a; o.we = w; o.wdata = d; o.is48 = w48;
    return o;
  endfunction

  function automatic logic out_of_range(input op_t o);
    return (o.addr >= 48'd16) || (o.is48 && (o.addr == 48'd15));
  endfunction

  function automatic exp_t predict(input op_t o);
    exp_t e;
    e.rdata = 48'd0;
    e.err   = 1'b0;
    if (o.en && model_ready) begin
      if (out_of_range(o)) e.err = 1'b1;
      else if (o.is48) e.rdata = {model[o.addr[3:0] + 4'd1], model[o.addr[3:0]]};
      else e.rdata = {24'd0, model[o.addr[3:0]]};
    end
    return e;
  endfunction

  task automatic apply_write(input op_t o);
    if (o.en && o.we && model_ready && !out_of_range(o)) begin
      model[o.addr[3:0]] = o.wdata[23:0];
      if (o.is48) model[o.addr[3:0] + 4'd1] = o.wdata[47:24];
    end
  endtask

  // Address cycle, then the data cycle where outputs are checked and writes commit.
  task automatic run_pair(input op_t o0, input op_t o1, input string tag);
    op_t ops[2];
    ops[0] = o0;
    ops[1] = o1;
    for (int p = 0; p < 2; p++) begin
      addr[p]   = ops[p].addr;
      addr_v[p] = ops[p].en;
      we[p]     = 1'b0;
      sb_q.push_back(predict(ops[p]));
    end
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      addr_v[p] = 1'b0;
      we[p]     = ops[p].en & ops[p].we;
      wdata[p]  = ops[p].wdata;
      is48[p]   = ops[p].is48;
    end
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        check_val($sformatf("%s_sb%0d", tag, p), 48'd0, 48'd1);
      end else begin
        e = sb_q.pop_front();
        check_val($sformatf("%s_rd%0d", tag, p), rdata[p], e.rdata);
        check_val($sformatf("%s_err%0d", tag, p), {47'd0, err[p]}, {47'd0, e.err});
      end
    end
    apply_write(o0);
    apply_write(o1);
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) we[p] = 1'b0;
  endtask

  // Counts edges until ready; optionally hammers port 0 with writes that must be ignored.
  task automatic wait_clear(input string tag, input logic poke);
    int edges = 0;
    while (ready !== 1'b1 && edges < 40) begin
      if (poke) begin
        addr[0]   = 48'(edges % 16);
        addr_v[0] = 1'b1;
        we[0]     = 1'b1;
        wdata[0]  = 48'hFFFFFF_FFFFFF;
        is48[0]   = edges[0];
      end
      @(posedge clk); #1;
      edges++;
      if (poke && ready !== 1'b1) begin
        check_val("clear_rd", rdata[0], 48'd0);
        check_val("clear_err", {47'd0, err[0]}, 48'd0);
      end
    end
    addr_v[0] = 1'b0;
    we[0]     = 1'b0;
    is48[0]   = 1'b0;
    check_val(tag, 48'(edges), 48'd16);
    model_ready = 1'b1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      run_pair(mk(i % 2 == 0, 48'(i), 1'b0, 48'd0, 1'b0),
               mk(i % 2 == 1, 48'(i), 1'b0, 48'd0, 1'b0), tag);
    end
  endtask

  initial begin
    op_t nop;
    nop = mk(1'b0, 48'd0, 1'b0, 48'd0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      addr[p] = 48'd0; addr_v[p] = 1'b0; we[p] = 1'b0; wdata[p] = 48'd0; is48[p] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 24'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", {47'd0, ready}, 48'd0);
    check_val("rst_rd0", rdata[0], 48'd0);
    check_val("rst_rd1", rdata[1], 48'd0);
    check_val("rst_err0", {47'd0, err[0]}, 48'd0);
    rst_n = 1'b1;
    wait_clear("clear_len", 1'b0);
    read_all("zero");

    run_pair(mk(1'b1, 48'd6, 1'b1, 48'h000000_ABCDEF, 1'b0), nop, "w6");
    run_pair(mk(1'b1, 48'd5, 1'b1, 48'h000000_123456, 1'b0), nop, "w5");
    run_pair(nop, mk(1'b1, 48'd5, 1'b0, 48'd0, 1'b0), "r5");
    run_pair(mk(1'b1, 48'd6, 1'b0, 48'd0, 1'b0), nop, "r6");

    run_pair(mk(1'b1, 48'd14, 1'b1, 48'hAABBCC_DDEEFF, 1'b1), nop, "w14");
    run_pair(mk(1'b1, 48'd14, 1'b0, 48'd0, 1'b0), mk(1'b1, 48'd15, 1'b0, 48'd0, 1'b0), "r14_15");
    run_pair(nop, mk(1'b1, 48'd14, 1'b0, 48'd0, 1'b1), "r14w");
    run_pair(mk(1'b1, 48'd15, 1'b1, 48'h010203_040506, 1'b1), nop, "w15w");
    run_pair(mk(1'b1, 48'd15, 1'b0, 48'd0, 1'b0), mk(1'b1, 48'd0, 1'b0, 48'd0, 1'b0), "r15_0");

    run_pair(mk(1'b1, 48'd3, 1'b1, 48'h000000_0A0A0A, 1'b0), nop, "pre3");
    run_pair(mk(1'b1, 48'd3, 1'b1, 48'h000000_111111, 1'b0),
             mk(1'b1, 48'd3, 1'b1, 48'h000000_222222, 1'b0), "coll3");
    run_pair(mk(1'b1, 48'd3, 1'b0, 48'd0, 1'b0), nop, "r3");
    run_pair(mk(1'b1, 48'd7, 1'b1, 48'h777777_070707, 1'b1),
             mk(1'b1, 48'd8, 1'b1, 48'h999999_888888, 1'b1), "ovl");
    run_pair(mk(1'b1, 48'd7, 1'b0, 48'd0, 1'b1), mk(1'b1, 48'd9, 1'b0, 48'd0, 1'b0), "r_ovl");

    run_pair(mk(1'b1, 48'h000000_100002, 1'b1, 48'h000000_5A5A5A, 1'b0), nop, "b20");
    run_pair(nop, mk(1'b1, 48'd16, 1'b1, 48'h000000_5A5A5A, 1'b0), "a16");
    run_pair(mk(1'b1, 48'd2, 1'b0, 48'd0, 1'b0), mk(1'b1, 48'd0, 1'b0, 48'd0, 1'b0), "r2_0");

    for (int n = 0; n < 40; n++) begin
      op_t r[2];
      for (int p = 0; p < 2; p++) begin
        r[p] = mk($urandom_range(0, 3) != 0, 48'($urandom_range(0, 17)), 1'($urandom_range(0, 1)),
                  48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 9) == 0) r[p].addr[20] = 1'b1;
      end
      run_pair(r[0], r[1], "rnd");
    end
    read_all("final");

    // Reset from READY, then again mid-clear at c=7.
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_from_ready", {47'd0, ready}, 48'd0);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check_val("mid_clear_ready", {47'd0, ready}, 48'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 24'd0;
    wait_clear("clear_len_restart", 1'b1);
    read_all("zero2");

    check_val("sb_empty", 48'(sb_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
